ls_encoder_queue: RTL
=====================

Name: ls_encoder_queue

Overview:
- Parametrised successor to the control unit's combinational instruction encoder.
- Decodes every 32-bit instruction class the control unit sequences into a microsequencer state number: load/store for byte and word in all addressing modes, data processing, branch, and illegal.
- Registers each decoded result into a FIFO so fetch and the control unit are decoupled by valid/ready handshakes.
- Sits between instruction register and control unit state sequencer.

Parameters:
STATE_W, 10, width of state_number; must be ≥8.
FIFO_DEPTH, 4, number of queued decoded entries; power of two, ≥2.
CNT_W, 8, width of illegal_count.
ILLEGAL_STATE, 1, state number emitted for unrecognised instructions.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  instruction presented.
in_ready  out  1  block can accept the instruction this cycle.
instruction  in  32  instruction word.
out_valid  out  1  head entry valid.
out_ready  in  1  control unit consumes head entry.
state_number  out  STATE_W  decoded state of head entry; 0 when empty.
illegal  out  1  head entry was unrecognised; 0 when empty.
occupancy  out  $clog2(FIFO_DEPTH)+1  entries held.
illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Decode (combinational, on instruction), bits [27:25]:
  - 010: immediate-offset load/store.
  - 011 with bit4=0: register-offset load/store.
  - 011 with bit4=1: illegal.
  - 00x: data processing.
  - 101: branch.
  - All else: illegal.
- Load/store mode index k, from P=bit24, W=bit21, and the I class:
  - Offset (P=1, W=0): imm k=0, reg k=1.
  - Pre-indexed (P=1, W=1): imm k=2, reg k=3.
  - Post-indexed (P=0): imm k=4, reg k=7.
- Load/store state = base + k + (U=bit23 ? 0 : 10), where base is:
  - Store byte (L=0, B=1): 20.
  - Store word (L=0, B=0): 40.
  - Load byte (L=1, B=1): 60.
  - Load word (L=1, B=0): 80.
- Store-byte values are fixed for control unit compatibility: 20, 30, 22, 32, 24, 34, 21, 31, 23, 33, 27, 37.
- Data processing: state = 100 + 2·opcode[24:21] + bit25 (range 100..131).
- Branch: state = 140 + bit24.
- Illegal: state = ILLEGAL_STATE, illegal flag = 1.
- All states are zero-extended to STATE_W.
- Handshake:
  - in_ready = (occupancy < FIFO_DEPTH), derived from registered count only. There is no push-while-full bypass, even if a pop occurs that cycle.
  - Push when in_valid && in_ready; pop when out_valid && out_ready.
  - Pushed entry {state, illegal} is written at the clock edge.
  - out_valid = (occupancy != 0).
- Latency: one cycle from accepting edge to out_valid on an empty queue. There is no same-cycle input-to-output bypass.
- Head outputs are valid throughout any stall and stay stable until popped.
- Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH: occupancy unchanged, head advances, new entry appended.
- Pop with no push when occupancy = 1: outputs go to 0 and out_valid = 0 next cycle.
- Read and write pointers wrap modulo FIFO_DEPTH.
- illegal_count increments on push of an illegal entry and saturates at 2^CNT_W−1.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and occupancy = 0; illegal_count = 0.
  - out_valid = 0, state_number = 0, illegal = 0, in_ready = 1.
  - Queued entries are discarded.
- instruction changes while in_valid=0 have no effect.

Test Plan:
- Reset, then push 0xE5C21004 (STRB offset add imm) with out_ready=0 → next cycle out_valid=1, state_number=20, illegal=0, occupancy=1; holds while stalled.
- Push 0xE4110008 (LDR post-index sub imm), 0xE0810002 (ADD reg), 0xEA000000 (B) back-to-back with out_ready=1 → pops in order: 94, 108, 140; occupancy never exceeds 1.
- Push 0xE7C21012 (reg offset, bit4=1) → state_number=1, illegal=1, illegal_count=1. Push illegal 300 times with CNT_W=8 → illegal_count=255.
- Fill 4 entries with out_ready=0 → in_ready=0 at occupancy=4 and a fifth push is ignored. Assert out_ready → entries drain in order; in_ready=1 the cycle after the first pop.
- Simultaneous push/pop at occupancy=2 for 8 cycles → occupancy stays 2, order preserved across pointer wrap.
- Assert reset mid-stream with occupancy=3 → outputs 0 immediately (asynchronous); after release, first push appears one cycle later with correct state.

Source files
------------

// File: rtl/ls_encoder_queue.sv
// Instruction-class encoder feeding a small FIFO of decoded microsequencer states.
// Fetch pushes raw instructions; the control unit pops {state_number, illegal} pairs.
module ls_encoder_queue #(
    parameter int unsigned STATE_W       = 10,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned ILLEGAL_STATE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   instruction,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [STATE_W-1:0]            state_number,
    output logic                          illegal,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]              illegal_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic               ls_p, ls_u, ls_b, ls_w, ls_l;
    logic               ls_is_reg;
    logic [7:0]         ls_base;
    logic [7:0]         ls_k;
    logic [7:0]         ls_state;
    logic [7:0]         dp_state;
    logic [7:0]         br_state;
    logic [STATE_W-1:0] dec_state;
    logic               dec_illegal;
    logic               unused_bits;

    assign ls_p = instruction[24];
    assign ls_u = instruction[23];
    assign ls_b = instruction[22];
    assign ls_w = instruction[21];
    assign ls_l = instruction[20];

    assign unused_bits = ^{instruction[31:28], instruction[19:5], instruction[3:0]};

    always_comb begin
        ls_is_reg = (instruction[27:25] == 3'b011);

        unique case ({ls_l, ls_b})
            2'b01:   ls_base = 8'd20;
            2'b00:   ls_base = 8'd40;
            2'b11:   ls_base = 8'd60;
            default: ls_base = 8'd80;
        endcase

        // Post-indexed register mode sits at k=7, not 5, to match the sequencer map.
        if (ls_p) begin
            ls_k = {6'd0, ls_w, ls_is_reg};
        end else begin
            ls_k = ls_is_reg ? 8'd7 : 8'd4;
        end

        ls_state = ls_base + ls_k + (ls_u ? 8'd0 : 8'd10);
        dp_state = 8'd100 + {3'd0, instruction[24:21], 1'b0} + {7'd0, instruction[25]};
        br_state = 8'd140 + {7'd0, instruction[24]};
    end

    always_comb begin
        dec_state   = STATE_W'(ILLEGAL_STATE);
        dec_illegal = 1'b1;
        case (instruction[27:25])
            3'b010: begin
                dec_state   = STATE_W'(ls_state);
                dec_illegal = 1'b0;
            end
            3'b011: begin
                if (!instruction[4]) begin
                    dec_state   = STATE_W'(ls_state);
                    dec_illegal = 1'b0;
                end
            end
            3'b000, 3'b001: begin
                dec_state   = STATE_W'(dp_state);
                dec_illegal = 1'b0;
            end
            3'b101: begin
                dec_state   = STATE_W'(br_state);
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] mem_state   [FIFO_DEPTH];
    logic               mem_illegal [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
    logic               push, pop;

    // in_ready looks only at the registered count: a full queue refuses even if it pops.
    assign in_ready  = (count_q < OCC_W'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (push && dec_illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Storage needs no reset; stale slots are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_state[wr_ptr_q]   <= dec_state;
            mem_illegal[wr_ptr_q] <= dec_illegal;
        end
    end

    assign state_number  = out_valid ? mem_state[rd_ptr_q] : '0;
    assign illegal       = out_valid ? mem_illegal[rd_ptr_q] : 1'b0;
    assign occupancy     = count_q;
    assign illegal_count = ill_cnt_q;

endmodule
